serial_to_parallel_8bit: RTL
============================

Name: serial_to_parallel_8bit

Overview:
Upstream feeder for the 8-bit load-enabled register. Assembles a framed serial bit stream into a parallel word. On frame completion it presents the word on data_out with a one-cycle load pulse, so data_out/load connect directly to the register's data_in/load. Tracks frame progress with a small FSM and bit counter, and flags aborted frames.

Parameters:
WIDTH, 8, word width in bits (register stage uses 8)
MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1]; 0 = first received bit lands in data_out[0]

Ports:
CLK  input  1  single clock; all state updates on rising edge
RST  input  1  reset, asynchronous, active-low (0 = reset)
frame_start  input  1  marks first bit of a frame; sampled on CLK rising edge
sin  input  1  serial data bit; sampled only when sin_valid=1
sin_valid  input  1  bit strobe; one bit consumed per cycle it is high
data_out  output  WIDTH  last completed word; held stable between completions
load  output  1  one-cycle pulse, high in the cycle data_out holds a newly completed word
busy  output  1  high while a frame is in progress (state SHIFT)
frame_err  output  1  one-cycle pulse: frame aborted by a new frame_start

Behaviour:
- Reset (RST=0, asynchronous, no clock required): state=IDLE, bit count=0, shift register=0, data_out=0, load=0, busy=0, frame_err=0. Partial frame discarded. Outputs stay at reset values while RST=0; normal operation starts at the first rising edge after RST returns to 1.
- All outputs are registered. load and frame_err default to 0 every cycle unless set by the rules below.
- Shift direction:
  - MSB_FIRST=1: shift left, and sin enters bit 0.
  - MSB_FIRST=0: shift right, and sin enters bit WIDTH-1.
- Bit counter: 0..WIDTH-1. Increments on each consumed bit. Never wraps silently; reaching WIDTH-1 with a consumed bit completes the frame.
- FSM states: IDLE, SHIFT.
  - IDLE:
    - sin_valid without frame_start: ignored, no state change.
    - frame_start=1: go to SHIFT and set count=0. If sin_valid=1 in the same cycle, that sin is consumed as frame bit 0 (count becomes 1).
  - SHIFT:
    - sin_valid=1 and frame_start=0: consume bit, count+1.
    - Gaps (sin_valid=0) are allowed indefinitely; no timeout.
  - Completion: in SHIFT, when sin_valid=1 and count=WIDTH-1, at that edge:
    - data_out receives the full assembled word (including the current bit).
    - load goes to 1 for exactly one cycle.
    - state goes to IDLE, count to 0, busy to 0.
  - Abort: in SHIFT, frame_start=1 on a cycle that is not a completion cycle:
    - frame_err pulses one cycle, and the partial word is discarded.
    - data_out and load are unchanged.
    - The new frame starts immediately: count=0, or 1 if sin_valid=1 and sin is consumed as the new bit 0. State stays SHIFT.
  - Simultaneous completion and frame_start: completion wins. The frame completes normally, no frame_err, and frame_start is ignored that cycle (the new frame must re-assert frame_start).
- Latency: the word is visible on data_out, with load=1, in the cycle after the edge that samples the final bit. The downstream register captures it on the following edge. Minimum frame-to-frame spacing: frame_start may be asserted in the cycle load is high (state is IDLE then), giving back-to-back frames of WIDTH cycles.
- busy=1 exactly while in SHIFT.

Test Plan:
- Reset: hold RST=0 with random sin/sin_valid/frame_start -> data_out=0x00, load=0, busy=0, frame_err=0. Deassert RST -> stays IDLE until frame_start.
- MSB-first frame: frame_start with bits 1,0,1,0,0,1,0,1 on 8 consecutive sin_valid cycles -> data_out=0xA5 and load=1 for one cycle after bit 8, then busy=0. Repeat with random sin_valid gaps -> same result, load single-cycle.
- MSB_FIRST=0 instance, same bit sequence -> data_out=0xA5 bit-reversed = 0xA5 check replaced by sequence 1,1,0,0,0,0,0,0 -> data_out=0x03.
- Abort: 3 bits of a frame, then frame_start plus bits 1,1,1,1,0,0,0,0 -> frame_err=1 one cycle, prior data_out unchanged, then data_out=0xF0 with load pulse.
- Back-to-back: frame 0x3C, frame_start asserted in the load cycle, then frame 0xC3 -> two load pulses 8 cycles apart with data 0x3C then 0xC3. frame_start on the completion cycle -> completes with no frame_err and no new frame.
- Async reset mid-frame: RST=0 between clock edges after 5 bits -> outputs clear immediately with no edge. A fresh frame 0x81 afterwards -> data_out=0x81 and no stale bits.

Source files
------------

// File: rtl/serial_to_parallel_8bit.sv
// Framed serial-to-parallel assembler: collects WIDTH bits per frame and presents the word
// with a one-cycle load pulse; a frame_start mid-frame aborts and restarts the frame.
module serial_to_parallel_8bit #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             frame_start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             load,
  output logic             busy,
  output logic             frame_err
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              load_q, load_d;
  logic              err_q, err_d;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) begin
      return {cur[WIDTH-2:0], b};
    end else begin
      return {b, cur[WIDTH-1:1]};
    end
  endfunction

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shift_d = shift_q;
    data_d  = data_q;
    load_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StShift;
          if (sin_valid) begin
            shift_d = shift_in('0, sin);
            count_d = CntW'(1);
          end else begin
            shift_d = '0;
            count_d = '0;
          end
        end
      end

      StShift: begin
        if (sin_valid && (count_q == LastIdx)) begin
          // Completion has priority over a coincident frame_start.
          data_d  = shift_in(shift_q, sin);
          load_d  = 1'b1;
          state_d = StIdle;
          count_d = '0;
          shift_d = '0;
        end else if (frame_start) begin
          // Abort: drop the partial word and restart in place.
          err_d = 1'b1;
          if (sin_valid) begin
            shift_d = shift_in('0, sin);
            count_d = CntW'(1);
          end else begin
            shift_d = '0;
            count_d = '0;
          end
        end else if (sin_valid) begin
          shift_d = shift_in(shift_q, sin);
          count_d = count_q + CntW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      count_q <= '0;
      shift_q <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign data_out  = data_q;
  assign load      = load_q;
  assign busy      = (state_q == StShift);
  assign frame_err = err_q;

endmodule
